// File: rtl/maze_pkg.sv
// Shared types and helpers for the maze generator.
// Cell/grid arithmetic is done in int and narrowed at the use site.
package maze_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PICK,
    S_CARVE,
    S_POP,
    S_FINISH
  } state_e;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  function automatic int clamp_n(int num, int max_n);
    int n;
    n = num;
    if (n < 3) n = 3;
    if (n > max_n) n = max_n;
    if (n % 2 == 0) n = n - 1;
    return n;
  endfunction

  function automatic int cell_to_bit(int cx, int cy, int n);
    return (2 * cy + 1) * n + 2 * cx + 1;
  endfunction

  function automatic logic [31:0] lfsr_taps(int w);
    case (w)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return 32'h1 << (w - 1);
    endcase
  endfunction

endpackage

// File: rtl/maze_lfsr.sv
// Right-shifting Galois LFSR; a zero seed is forced to 1.
// Load wins over the free-running advance.
module maze_lfsr
  import maze_pkg::*;
#(
  parameter int LFSR_W = 16
) (
  input  logic              clk,
  input  logic              rst_sys,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  always_comb begin
    q_d = {1'b0, q_q[LFSR_W-1:1]} ^ (q_q[0] ? TAPS : '0);
    if (load) q_d = (seed == '0) ? LFSR_W'(1) : seed;
  end

  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) q_q <= LFSR_W'(1);
    else         q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/maze_gen_seq.sv
// Random-DFS backtracker maze generator over an odd NxN grid.
// map bit r*n+c is 1 for path; stack holds packed {cy,cx} cells.
module maze_gen_seq
  import maze_pkg::*;
#(
  parameter int MAX_N  = 19,
  parameter int NUM_W  = 5,
  parameter int LFSR_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_sys,
  input  logic                   start,
  input  logic [NUM_W-1:0]       num,
  input  logic                   seed_load,
  input  logic [LFSR_W-1:0]      seed,
  output logic                   busy,
  output logic                   done,
  output logic                   map_valid,
  output logic [MAX_N*MAX_N-1:0] map,
  output logic [NUM_W-1:0]       actual_num
);

  localparam int KMAX      = (MAX_N - 1) / 2;
  localparam int MAX_CELLS = KMAX * KMAX;
  localparam int SP_W      = $clog2(MAX_CELLS + 1);
  localparam int CW        = $clog2(KMAX + 1);
  localparam int MW        = MAX_N * MAX_N;
  localparam int IW        = $clog2(MW);

  state_e            state_q, state_d;
  logic [MW-1:0]     map_q, map_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [NUM_W-1:0]  actual_num_q, actual_num_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              map_valid_q, map_valid_d;
  logic [CW-1:0]     nx_q, nx_d, ny_q, ny_d;
  logic [IW-1:0]     wb_q, wb_d, cb_q, cb_d;

  logic [2*CW-1:0]   stack_q [MAX_CELLS];
  logic              push_en;
  logic [SP_W-1:0]   push_idx;
  logic [2*CW-1:0]   push_cell;

  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_unused;

  logic [2*CW-1:0]   top_c;
  int                n_i, k_i, tx_i, ty_i, cx_i, cy_i, t_bit, c_bit;
  dir_e              d;
  logic              ok, found;
  logic [CW-1:0]     fx, fy;
  logic [IW-1:0]     f_cb, f_wb;

  maze_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
    .clk     (clk),
    .rst_sys (rst_sys),
    .load    (seed_load),
    .seed    (seed),
    .q       (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[LFSR_W-1:2];

  // Scan the four neighbours of the top cell, starting at a random direction.
  always_comb begin
    n_i   = int'(actual_num_q);
    k_i   = (n_i - 1) / 2;
    top_c = stack_q[sp_q - 1'b1];
    tx_i  = int'(top_c[CW-1:0]);
    ty_i  = int'(top_c[2*CW-1:CW]);
    t_bit = cell_to_bit(tx_i, ty_i, n_i);
    found = 1'b0;
    fx    = '0;
    fy    = '0;
    f_cb  = '0;
    f_wb  = '0;
    d     = DIR_N;
    ok    = 1'b0;
    cx_i  = tx_i;
    cy_i  = ty_i;
    c_bit = t_bit;
    for (int i = 0; i < 4; i++) begin
      d    = dir_e'(lfsr_q[1:0] + 2'(i));
      cx_i = tx_i;
      cy_i = ty_i;
      unique case (d)
        DIR_N: begin ok = ty_i > 0;       cy_i = ty_i - 1; end
        DIR_E: begin ok = tx_i < k_i - 1; cx_i = tx_i + 1; end
        DIR_S: begin ok = ty_i < k_i - 1; cy_i = ty_i + 1; end
        DIR_W: begin ok = tx_i > 0;       cx_i = tx_i - 1; end
      endcase
      c_bit = cell_to_bit(cx_i, cy_i, n_i);
      if (ok && !found) begin
        if (!map_q[IW'(c_bit)]) begin
          found = 1'b1;
          fx    = CW'(cx_i);
          fy    = CW'(cy_i);
          f_cb  = IW'(c_bit);
          f_wb  = IW'((c_bit + t_bit) / 2);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    map_d        = map_q;
    sp_d         = sp_q;
    actual_num_d = actual_num_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    map_valid_d  = map_valid_q;
    nx_d         = nx_q;
    ny_d         = ny_q;
    wb_d         = wb_q;
    cb_d         = cb_q;
    push_en      = 1'b0;
    push_idx     = sp_q;
    push_cell    = {ny_q, nx_q};
    case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          actual_num_d = NUM_W'(clamp_n(int'(num), MAX_N));
          busy_d       = 1'b1;
          map_valid_d  = 1'b0;
          state_d      = S_CLEAR;
        end
      end
      S_CLEAR: begin
        map_d                = '0;
        map_d[IW'(n_i + 1)]  = 1'b1;
        push_en              = 1'b1;
        push_idx             = '0;
        push_cell            = '0;
        sp_d                 = SP_W'(1);
        state_d              = S_PICK;
      end
      S_PICK: begin
        if (found) begin
          nx_d    = fx;
          ny_d    = fy;
          cb_d    = f_cb;
          wb_d    = f_wb;
          state_d = S_CARVE;
        end else begin
          // Dead end backtracks in this same cycle.
          sp_d    = sp_q - 1'b1;
          state_d = (sp_q == SP_W'(1)) ? S_FINISH : S_PICK;
        end
      end
      S_CARVE: begin
        map_d[wb_q] = 1'b1;
        map_d[cb_q] = 1'b1;
        push_en     = 1'b1;
        sp_d        = sp_q + 1'b1;
        state_d     = S_PICK;
      end
      S_FINISH: begin
        map_d[IW'((n_i - 2) * n_i + n_i - 2)] = 1'b1;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        map_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      state_q      <= S_IDLE;
      map_q        <= '0;
      sp_q         <= '0;
      actual_num_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      map_valid_q  <= 1'b0;
      nx_q         <= '0;
      ny_q         <= '0;
      wb_q         <= '0;
      cb_q         <= '0;
    end else begin
      state_q      <= state_d;
      map_q        <= map_d;
      sp_q         <= sp_d;
      actual_num_q <= actual_num_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      map_valid_q  <= map_valid_d;
      nx_q         <= nx_d;
      ny_q         <= ny_d;
      wb_q         <= wb_d;
      cb_q         <= cb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= push_cell;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign map_valid  = map_valid_q;
  assign map        = map_q;
  assign actual_num = actual_num_q;

endmodule

// File: tb/tb_maze_gen_seq.sv
// Bench for maze_gen_seq: vector table plus random vectors, checked
// against maze graph properties, then handshake/reset/determinism cases.
module tb_maze_gen_seq;

  localparam int MAX_N  = 19;
  localparam int NUM_W  = 5;
  localparam int LFSR_W = 16;
  localparam int MW     = MAX_N * MAX_N;

  logic              clk = 1'b0;
  logic              rst_sys;
  logic              start;
  logic [NUM_W-1:0]  num;
  logic              seed_load;
  logic [LFSR_W-1:0] seed;
  logic              busy;
  logic              done;
  logic              map_valid;
  logic [MW-1:0]     map;
  logic [NUM_W-1:0]  actual_num;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          num;
    logic [15:0] seed;
    int          exp_n;
  } vec_t;

  vec_t tbl[$];

  maze_gen_seq #(.MAX_N(MAX_N), .NUM_W(NUM_W), .LFSR_W(LFSR_W)) dut (
    .clk        (clk),
    .rst_sys    (rst_sys),
    .start      (start),
    .num        (num),
    .seed_load  (seed_load),
    .seed       (seed),
    .busy       (busy),
    .done       (done),
    .map_valid  (map_valid),
    .map        (map),
    .actual_num (actual_num)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_n(int v);
    int n;
    n = (v < 3) ? 3 : ((v > MAX_N) ? MAX_N : v);
    return (n % 2 == 0) ? n - 1 : n;
  endfunction

  task automatic analyse(input logic [MW-1:0] m, input int n,
                         output int paths, output int miss,
                         output int bord, output int high,
                         output int reach, output int edges);
    bit vis [MW];
    int q[$];
    int cur, r, c, nr, nc, idx;
    paths = 0; miss = 0; bord = 0; high = 0; reach = 0; edges = 0;
    for (int i = 0; i < MW; i++) vis[i] = 1'b0;
    for (int rr = 0; rr < n; rr++) begin
      for (int cc = 0; cc < n; cc++) begin
        idx = rr * n + cc;
        if (m[idx]) paths++;
        if ((rr == 0 || cc == 0 || rr == n - 1 || cc == n - 1) && m[idx]) bord++;
        if ((rr % 2 == 1) && (cc % 2 == 1) && !m[idx]) miss++;
        if (m[idx] && cc + 1 < n && m[idx + 1]) edges++;
        if (m[idx] && rr + 1 < n && m[idx + n]) edges++;
      end
    end
    for (int i = n * n; i < MW; i++) if (m[i]) high++;
    if (m[n + 1]) begin
      vis[n + 1] = 1'b1;
      q.push_back(n + 1);
    end
    while (q.size() > 0) begin
      cur = q.pop_front();
      reach++;
      r = cur / n;
      c = cur % n;
      for (int k = 0; k < 4; k++) begin
        nr = r + ((k == 0) ? -1 : (k == 2) ? 1 : 0);
        nc = c + ((k == 3) ? -1 : (k == 1) ? 1 : 0);
        if (nr >= 0 && nr < n && nc >= 0 && nc < n) begin
          idx = nr * n + nc;
          if (m[idx] && !vis[idx]) begin
            vis[idx] = 1'b1;
            q.push_back(idx);
          end
        end
      end
    end
  endtask

  task automatic run_gen(input int nm, input logic [15:0] sd, input bit ld,
                         input int poke_at, output int lat, output bit to,
                         output int mv_bad, output int pulses);
    num       = NUM_W'(nm);
    seed      = sd;
    seed_load = ld;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    seed_load = 1'b0;
    lat       = 1;
    mv_bad    = 0;
    pulses    = 0;
    while (!done && lat < 400) begin
      if (busy && map_valid) mv_bad++;
      start = (lat == poke_at);
      if (lat == poke_at) num = NUM_W'(3);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    to    = !done;
    for (int i = 0; i < 3; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_result(input string tag, input int exp_n, input int lat,
                              input bit to, input int mv_bad, input int pulses);
    int k, paths, miss, bord, high, reach, edges;
    k = (exp_n - 1) / 2;
    analyse(map, exp_n, paths, miss, bord, high, reach, edges);
    chk({tag, " timeout"}, to, 0);
    chk({tag, " actual_num"}, actual_num, exp_n);
    chk({tag, " path_bits"}, paths, 2 * k * k - 1);
    chk({tag, " cells_missing"}, miss, 0);
    chk({tag, " border_bits"}, bord, 0);
    chk({tag, " high_bits"}, high, 0);
    chk({tag, " bfs_reach"}, reach, paths);
    chk({tag, " edges"}, edges, paths - 1);
    chk({tag, " latency_ok"}, (lat <= 3 * k * k + 3), 1);
    chk({tag, " busy_after"}, busy, 0);
    chk({tag, " map_valid_after"}, map_valid, 1);
    chk({tag, " map_valid_while_busy"}, mv_bad, 0);
    chk({tag, " done_pulses"}, pulses, 1);
  endtask

  initial begin
    int lat, mv_bad, pulses;
    bit to;
    logic [MW-1:0] m1, m2, exp1;

    rst_sys = 1'b1; start = 1'b0; seed_load = 1'b0; num = '0; seed = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset map_valid", map_valid, 0);
    chk("reset map_zero", (map == '0), 1);
    chk("reset actual_num", actual_num, 0);
    rst_sys = 1'b0;
    @(posedge clk); #1;

    // T1: smallest maze, a single cell
    exp1 = '0;
    exp1[4] = 1'b1;
    run_gen(3, 16'h0001, 1'b0, -1, lat, to, mv_bad, pulses);
    chk("t1 map", (map == exp1), 1);
    chk("t1 latency_le6", (lat <= 6), 1);
    check_result("t1", 3, lat, to, mv_bad, pulses);

    tbl.push_back('{6,  16'h00A5, 5});
    tbl.push_back('{31, 16'hBEEF, 19});
    tbl.push_back('{0,  16'h0007, 3});
    tbl.push_back('{2,  16'h3C3C, 3});
    tbl.push_back('{4,  16'h0F0F, 3});
    tbl.push_back('{19, 16'h5555, 19});
    tbl.push_back('{20, 16'hAAAA, 19});
    tbl.push_back('{12, 16'h1357, 11});
    tbl.push_back('{7,  16'hFFFF, 7});
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v.num   = int'($urandom_range(0, 31));
      v.seed  = 16'($urandom);
      v.exp_n = model_n(v.num);
      tbl.push_back(v);
    end
    foreach (tbl[i]) begin
      run_gen(tbl[i].num, tbl[i].seed, 1'b1, -1, lat, to, mv_bad, pulses);
      check_result($sformatf("vec%0d_num%0d", i, tbl[i].num), tbl[i].exp_n,
                   lat, to, mv_bad, pulses);
    end

    // T4: second start while busy must be ignored
    run_gen(19, 16'h2468, 1'b1, 5, lat, to, mv_bad, pulses);
    check_result("t4", 19, lat, to, mv_bad, pulses);

    // T5: deterministic from seed; zero seed acts as one
    run_gen(11, 16'h1234, 1'b1, -1, lat, to, mv_bad, pulses);
    m1 = map;
    run_gen(11, 16'h1234, 1'b1, -1, lat, to, mv_bad, pulses);
    m2 = map;
    chk("t5 same_seed_same_map", (m1 == m2), 1);
    check_result("t5", 11, lat, to, mv_bad, pulses);
    run_gen(9, 16'h0000, 1'b1, -1, lat, to, mv_bad, pulses);
    m1 = map;
    run_gen(9, 16'h0001, 1'b1, -1, lat, to, mv_bad, pulses);
    m2 = map;
    chk("t5 seed0_eq_seed1", (m1 == m2), 1);

    // T6: reset in the middle of a generation
    num = NUM_W'(19); seed = 16'h7777; seed_load = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; seed_load = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t6 busy_before_reset", busy, 1);
    rst_sys = 1'b1;
    @(posedge clk); #1;
    chk("t6 reset busy", busy, 0);
    chk("t6 reset map_zero", (map == '0), 1);
    chk("t6 reset map_valid", map_valid, 0);
    rst_sys = 1'b0;
    @(posedge clk); #1;
    run_gen(13, 16'h9ABC, 1'b1, -1, lat, to, mv_bad, pulses);
    check_result("t6_after", 13, lat, to, mv_bad, pulses);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
